// File: rtl/lockout_pkg.sv
// Shared types and constants for the lockout controller.
package lockout_pkg;

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    // Active-low {red,green,blue}
    localparam logic [2:0] LED_ARMED = 3'b110;
    localparam logic [2:0] LED_OPEN  = 3'b101;
    localparam logic [2:0] LED_LOCK  = 3'b011;
    localparam logic [2:0] LED_OFF   = 3'b111;

endpackage

// File: rtl/lockout_ctrl_sec_ticker.sv
// sec_ticker: emits a one-cycle tick every TICK_CYC cycles.
// A synchronous restart clears the count so the next tick lands TICK_CYC
// cycles after the restart edge.
module sec_ticker #(
    parameter int TICK_CYC = 12_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    // Next count: clear on restart or wrap, else increment
    always_comb begin
        cnt_d = cnt_q;
        if (restart || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lockout_ctrl.sv
// lockout_ctrl: lock policy downstream of the password compare stage.
// ARMED -> OPEN on a correct code, ARMED -> LOCKOUT after MAX_TRIES
// consecutive wrong codes; OPEN and LOCKOUT are timed in whole seconds.
// Optional feature macro: LOCKOUT_BUZZER_EN (buzzer tone during LOCKOUT).
module lockout_ctrl
    import lockout_pkg::*;
#(
    parameter int TICK_CYC   = 12_000_000,
    parameter int OPEN_TICKS = 5,
    parameter int LOCK_TICKS = 10,
    parameter int MAX_TRIES  = 3,
    parameter int BUZZ_HALF  = 3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       chk,
    input  logic       ok,
    input  logic       relock,
    output logic       unlocked,
    output logic [2:0] led,
    output logic [2:0] tries_left,
    output logic [7:0] sec_left,
    output logic       buzzer
);

    localparam logic [2:0] TRIES_MAX = 3'(MAX_TRIES);
    localparam logic [7:0] SEC_OPEN  = 8'(OPEN_TICKS);
    localparam logic [7:0] SEC_LOCK  = 8'(LOCK_TICKS);

    state_t     state_q, state_d;
    logic [2:0] tries_q, tries_d;
    logic [7:0] sec_q, sec_d;
    logic [2:0] led_q, led_d;
    logic       unl_q, unl_d;
    logic       win_restart;
    logic       restart;
    logic       tick;

    // Prescaler restarts on every state entry and on every OPEN window restart
    sec_ticker #(.TICK_CYC(TICK_CYC)) u_ticker (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // Next-state, counters and decoded outputs
    always_comb begin
        state_d     = state_q;
        tries_d     = tries_q;
        sec_d       = sec_q;
        win_restart = 1'b0;
        case (state_q)
            ARMED: begin
                // chk takes priority; relock alone has no effect here
                if (chk) begin
                    if (ok) begin
                        state_d = OPEN;
                        tries_d = TRIES_MAX;
                        sec_d   = SEC_OPEN;
                    end else if (tries_q > 3'd1) begin
                        tries_d = tries_q - 3'd1;
                    end else begin
                        state_d = LOCKOUT;
                        tries_d = TRIES_MAX;
                        sec_d   = SEC_LOCK;
                    end
                end
            end
            OPEN: begin
                // relock beats a simultaneous chk; a wrong code is ignored
                if (relock) begin
                    state_d = ARMED;
                    sec_d   = 8'd0;
                end else if (chk && ok) begin
                    sec_d       = SEC_OPEN;
                    win_restart = 1'b1;
                end else if (tick) begin
                    if (sec_q <= 8'd1) begin
                        state_d = ARMED;
                        sec_d   = 8'd0;
                    end else begin
                        sec_d = sec_q - 8'd1;
                    end
                end
            end
            LOCKOUT: begin
                if (tick) begin
                    if (sec_q <= 8'd1) begin
                        state_d = ARMED;
                        sec_d   = 8'd0;
                    end else begin
                        sec_d = sec_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = ARMED;
                tries_d = TRIES_MAX;
                sec_d   = 8'd0;
            end
        endcase

        restart = win_restart || (state_d != state_q);

        led_d = LED_OFF;
        unl_d = 1'b0;
        case (state_d)
            ARMED:   led_d = LED_ARMED;
            OPEN: begin
                led_d = LED_OPEN;
                unl_d = 1'b1;
            end
            LOCKOUT: led_d = LED_LOCK;
            default: led_d = LED_ARMED;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARMED;
            tries_q <= TRIES_MAX;
            sec_q   <= 8'd0;
            led_q   <= LED_ARMED;
            unl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            sec_q   <= sec_d;
            led_q   <= led_d;
            unl_q   <= unl_d;
        end
    end

    assign unlocked   = unl_q;
    assign led        = led_q;
    assign tries_left = tries_q;
    assign sec_left   = sec_q;

`ifdef LOCKOUT_BUZZER_EN
    localparam int BW = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;
    localparam logic [BW-1:0] BLAST = BW'(BUZZ_HALF - 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          buzz_q, buzz_d;

    // Square wave while staying in LOCKOUT; silent on entry, exit and elsewhere
    always_comb begin
        bcnt_d = '0;
        buzz_d = 1'b0;
        if (state_d == LOCKOUT && state_q == LOCKOUT) begin
            if (bcnt_q == BLAST) begin
                bcnt_d = '0;
                buzz_d = ~buzz_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
                buzz_d = buzz_q;
            end
        end
    end

    // Buzzer divider register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q <= '0;
            buzz_q <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            buzz_q <= buzz_d;
        end
    end

    assign buzzer = buzz_q;
`else
    // Constant 0; BUZZ_HALF stays in the header so both builds share one interface
    assign buzzer = (BUZZ_HALF < 0) ? 1'b1 : 1'b0;
`endif

endmodule

// File: tb/tb_lockout_ctrl.sv
// Bench for lockout_ctrl: reset checks, a vector table, timed corner
// sequences, async reset mid-LOCKOUT, then random traffic against a
// cycle-count reference model.
module tb_lockout_ctrl;

    localparam int TICK = 4;
    localparam int OT   = 2;
    localparam int LT   = 3;
    localparam int MT   = 3;
    localparam int BH   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       chk;
    logic       ok;
    logic       relock;
    logic       unlocked;
    logic [2:0] led;
    logic [2:0] tries_left;
    logic [7:0] sec_left;
    logic       buzzer;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0=armed 1=open 2=lockout, elapsed cycles since entry/restart
    int m_mode;
    int m_tries;
    int m_el;

    typedef struct {
        logic       c;
        logic       o;
        logic       r;
        logic [2:0] led;
        logic       unl;
        logic [2:0] tries;
        logic [7:0] sec;
    } vec_t;

    vec_t tbl[10];

    lockout_ctrl #(
        .TICK_CYC   (TICK),
        .OPEN_TICKS (OT),
        .LOCK_TICKS (LT),
        .MAX_TRIES  (MT),
        .BUZZ_HALF  (BH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .chk        (chk),
        .ok         (ok),
        .relock     (relock),
        .unlocked   (unlocked),
        .led        (led),
        .tries_left (tries_left),
        .sec_left   (sec_left),
        .buzzer     (buzzer)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_tries = MT;
        m_el    = 0;
    endtask

    task automatic model_edge(input logic c, input logic o, input logic r);
        case (m_mode)
            0: if (c) begin
                if (o) begin
                    m_mode = 1; m_tries = MT; m_el = 0;
                end else if (m_tries > 1) begin
                    m_tries--;
                end else begin
                    m_mode = 2; m_tries = MT; m_el = 0;
                end
            end
            1: begin
                if (r) begin
                    m_mode = 0; m_el = 0;
                end else if (c && o) begin
                    m_el = 0;
                end else begin
                    m_el++;
                    if (m_el == OT * TICK) begin m_mode = 0; m_el = 0; end
                end
            end
            default: begin
                m_el++;
                if (m_el == LT * TICK) begin m_mode = 0; m_el = 0; end
            end
        endcase
    endtask

    task automatic check_model();
        int e_led, e_sec, e_buz;
        e_led = (m_mode == 0) ? 6 : (m_mode == 1) ? 5 : 3;
        e_sec = (m_mode == 0) ? 0 : (m_mode == 1) ? OT - m_el / TICK : LT - m_el / TICK;
        e_buz = 0;
`ifdef LOCKOUT_BUZZER_EN
        if (m_mode == 2) e_buz = (m_el / BH) % 2;
`endif
        check("m_led", int'(led), e_led);
        check("m_unlocked", int'(unlocked), (m_mode == 1) ? 1 : 0);
        check("m_tries", int'(tries_left), m_tries);
        check("m_sec", int'(sec_left), e_sec);
        check("m_buzzer", int'(buzzer), e_buz);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare after it
    task automatic step(input logic c, input logic o, input logic r);
        chk = c; ok = o; relock = r;
        @(posedge clk);
        model_edge(c, o, r);
        #1;
        chk = 1'b0; ok = 1'b0; relock = 1'b0;
        check_model();
    endtask

    initial begin
        int cyc;

        tbl[0] = '{c:1, o:0, r:0, led:3'b110, unl:0, tries:3'd2, sec:8'd0};
        tbl[1] = '{c:1, o:0, r:0, led:3'b110, unl:0, tries:3'd1, sec:8'd0};
        tbl[2] = '{c:1, o:1, r:0, led:3'b101, unl:1, tries:3'd3, sec:8'd2};
        tbl[3] = '{c:1, o:1, r:1, led:3'b110, unl:0, tries:3'd3, sec:8'd0};
        tbl[4] = '{c:0, o:0, r:1, led:3'b110, unl:0, tries:3'd3, sec:8'd0};
        tbl[5] = '{c:1, o:0, r:0, led:3'b110, unl:0, tries:3'd2, sec:8'd0};
        tbl[6] = '{c:1, o:0, r:0, led:3'b110, unl:0, tries:3'd1, sec:8'd0};
        tbl[7] = '{c:1, o:0, r:0, led:3'b011, unl:0, tries:3'd3, sec:8'd3};
        tbl[8] = '{c:1, o:1, r:0, led:3'b011, unl:0, tries:3'd3, sec:8'd3};
        tbl[9] = '{c:0, o:0, r:1, led:3'b011, unl:0, tries:3'd3, sec:8'd3};

        // Reset
        rst = 1'b1; chk = 1'b0; ok = 1'b0; relock = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_led", int'(led), 6);
        check("rst_unlocked", int'(unlocked), 0);
        check("rst_tries", int'(tries_left), 3);
        check("rst_sec", int'(sec_left), 0);
        check("rst_buzzer", int'(buzzer), 0);

        // Correct code opens for exactly OT*TICK cycles
        step(1'b1, 1'b1, 1'b0);
        check("open_led", int'(led), 5);
        check("open_unlocked", int'(unlocked), 1);
        check("open_sec", int'(sec_left), 2);
        cyc = 0;
        while (led != 3'b110 && cyc < 20) begin
            step(1'b0, 1'b0, 1'b0);
            cyc++;
            if (cyc == 4) check("open_sec_after4", int'(sec_left), 1);
        end
        check("open_len", cyc, 8);

        // Vector table: wrong codes, relock priority, entry to LOCKOUT
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].c, tbl[i].o, tbl[i].r);
            check($sformatf("tbl%0d_led", i), int'(led), int'(tbl[i].led));
            check($sformatf("tbl%0d_unl", i), int'(unlocked), int'(tbl[i].unl));
            check($sformatf("tbl%0d_tries", i), int'(tries_left), int'(tbl[i].tries));
            check($sformatf("tbl%0d_sec", i), int'(sec_left), int'(tbl[i].sec));
        end
        // LOCKOUT entered at table row 7; two cycles already elapsed
        cyc = 2;
        while (led != 3'b110 && cyc < 30) begin
            step(1'b0, 1'b0, 1'b0);
            cyc++;
        end
        check("lock_len", cyc, 12);

        // Window restart after 3 cycles of OPEN
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("restart_sec", int'(sec_left), 2);
        cyc = 0;
        while (led != 3'b110 && cyc < 20) begin
            step(1'b0, 1'b0, 1'b0);
            cyc++;
        end
        check("restart_len", cyc, 8);

        // Asynchronous reset between edges mid-LOCKOUT
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("arst_led", int'(led), 6);
        check("arst_buzzer", int'(buzzer), 0);
        check("arst_sec", int'(sec_left), 0);
        check("arst_tries", int'(tries_left), 3);
        check("arst_unlocked", int'(unlocked), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
